// File: rtl/vermibus_ram.sv
// Vermibus responder RAM: address window decode, wait states, byte-lane writes.
// Optional write protection of the low ROM_WORDS words with VERMIBUS_RAM_ROM_PROTECT_EN.
module vermibus_ram #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          SIZE_WORDS   = 1024,
  parameter int          WAIT_STATES  = 0,
  parameter int          ROM_WORDS    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] address,
  input  logic [3:0]  wstrobe,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        irq
);
  localparam int          AW      = $clog2(SIZE_WORDS);
  // 33-bit window bounds so a window ending at 4 GiB does not wrap to zero
  localparam logic [32:0] WIN_LO  = {1'b0, BASE_ADDRESS};
  localparam logic [32:0] WIN_HI  = WIN_LO + 33'(SIZE_WORDS) * 33'd4;
  localparam logic [3:0]  WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [31:0]     mem [SIZE_WORDS];
  logic [AW-1:0]   index, idx_q;
  logic [3:0]      strb_q;
  logic            sel, enter_ack, commit, wr_ok;

  assign sel   = valid && ({1'b0, address} >= WIN_LO) && ({1'b0, address} < WIN_HI);
  assign index = AW'((address - BASE_ADDRESS) >> 2);
  assign ready = (state == ACK) && valid;
  assign irq   = 1'b0;

`ifdef VERMIBUS_RAM_ROM_PROTECT_EN
  assign wr_ok = (32'(idx_q) >= $unsigned(ROM_WORDS));
`else
  // protection compiled out: ROM_WORDS has no effect
  assign wr_ok = 1'b1 | (ROM_WORDS < 0);
`endif

  assign commit = ready && (|strb_q) && wr_ok && !reset;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    enter_ack = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          if (WAIT_STATES > 0) begin
            state_nx = WAIT;
            cnt_nx   = WS_INIT;
          end else begin
            state_nx  = ACK;
            enter_ack = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!valid) begin
          state_nx = IDLE;
        end else if (cnt == 4'd0) begin
          state_nx  = ACK;
          enter_ack = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (enter_ack) rdata <= mem[index];
    end
  end

  // index and strobes are captured on entry to ACK; the write lands as ACK ends
  always_ff @(posedge clk) begin
    if (enter_ack) begin
      idx_q  <= index;
      strb_q <= wstrobe;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int n = 0; n < 4; n++) begin
        if (strb_q[n]) mem[idx_q][8*n +: 8] <= wdata[8*n +: 8];
      end
    end
  end
endmodule

// File: tb/tb_vermibus_ram.sv
// Directed bench for vermibus_ram: three instances with 0, 2 and 3 wait states.
module tb_vermibus_ram;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      address = '0;
  logic [31:0]      wdata = '0;
  logic [3:0]       wstrobe = '0;
  logic [2:0]       vld = '0;
  logic [2:0][31:0] rd;
  logic [2:0]       rdy;
  logic [2:0]       irq;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vermibus_ram #(.BASE_ADDRESS(32'h0000A000), .SIZE_WORDS(256), .WAIT_STATES(0), .ROM_WORDS(0)) u_ws0 (
    .clk(clk), .reset(reset), .valid(vld[0]), .address(address), .wstrobe(wstrobe),
    .wdata(wdata), .rdata(rd[0]), .ready(rdy[0]), .irq(irq[0]));
  vermibus_ram #(.BASE_ADDRESS(32'h0000A000), .SIZE_WORDS(256), .WAIT_STATES(2), .ROM_WORDS(4)) u_ws2 (
    .clk(clk), .reset(reset), .valid(vld[1]), .address(address), .wstrobe(wstrobe),
    .wdata(wdata), .rdata(rd[1]), .ready(rdy[1]), .irq(irq[1]));
  vermibus_ram #(.BASE_ADDRESS(32'h0000A000), .SIZE_WORDS(256), .WAIT_STATES(3), .ROM_WORDS(0)) u_ws3 (
    .clk(clk), .reset(reset), .valid(vld[2]), .address(address), .wstrobe(wstrobe),
    .wdata(wdata), .rdata(rd[2]), .ready(rdy[2]), .irq(irq[2]));

  typedef struct {
    string       name;
    int          d;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] w;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(string nm, int d, logic [31:0] a, logic [3:0] s,
                              logic [31:0] w, logic [31:0] exp, int lat);
    vec_t v;
    v.name = nm; v.d = d; v.a = a; v.s = s; v.w = w; v.exp = exp; v.lat = lat;
    return v;
  endfunction

  // One transfer, entered and left at a falling edge; valid is held through the ACK cycle.
  task automatic xfer(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w,
                      output logic [31:0] r, output int lat);
    address = a; wstrobe = s; wdata = w; vld[d] = 1'b1;
    lat = -1; r = 'x;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rdy[d]) begin
        lat = i; r = rd[d];
        break;
      end
    end
    @(negedge clk);
    check("ready_single_pulse", 32'(rdy[d]), 32'd0);
    vld[d] = 1'b0;
  endtask

  task automatic hold_out(input int d, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] w, output int hits);
    address = a; wstrobe = s; wdata = w; vld[d] = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy[d]) hits++;
    end
    vld[d] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] r, old;
    int lat, t1, t2, hits;

    tbl.push_back(mk("w_word",      0, 32'hA100, 4'hF, 32'h00000096, 'x,           1));
    tbl.push_back(mk("r_word",      0, 32'hA100, 4'h0, 32'h0,        32'h00000096, 1));
    tbl.push_back(mk("w_clear",     0, 32'hA100, 4'hF, 32'h00000000, 'x,           1));
    tbl.push_back(mk("w_lane32",    0, 32'hA102, 4'hC, 32'h00960096, 'x,           1));
    tbl.push_back(mk("w_lane0",     0, 32'hA100, 4'h1, 32'h96969696, 'x,           1));
    tbl.push_back(mk("w_lane3",     0, 32'hA100, 4'h8, 32'h96969696, 'x,           1));
    tbl.push_back(mk("r_lanes",     0, 32'hA100, 4'h0, 32'h0,        32'h96960096, 1));
    tbl.push_back(mk("w_top",       0, 32'hA3FC, 4'hF, 32'hCAFEF00D, 'x,           1));
    tbl.push_back(mk("r_top",       0, 32'hA3FC, 4'h0, 32'h0,        32'hCAFEF00D, 1));
    tbl.push_back(mk("w_word0",     0, 32'hA000, 4'hF, 32'h11111111, 'x,           1));
    tbl.push_back(mk("r_word0",     0, 32'hA000, 4'h0, 32'h0,        32'h11111111, 1));
    tbl.push_back(mk("r_unaligned", 0, 32'hA001, 4'h0, 32'h0,        32'h11111111, 1));
    tbl.push_back(mk("w_ws2",       1, 32'hA104, 4'hF, 32'h0BADF00D, 'x,           3));
    tbl.push_back(mk("r_ws2",       1, 32'hA104, 4'h0, 32'h0,        32'h0BADF00D, 3));
    tbl.push_back(mk("w_ws2_w4",    1, 32'hA010, 4'hF, 32'h5A5A5A5A, 'x,           3));
    tbl.push_back(mk("r_ws2_w4",    1, 32'hA010, 4'h0, 32'h0,        32'h5A5A5A5A, 3));
    tbl.push_back(mk("w_ws3",       2, 32'hA010, 4'hF, 32'hAAAA5555, 'x,           4));
    tbl.push_back(mk("r_ws3",       2, 32'hA010, 4'h0, 32'h0,        32'hAAAA5555, 4));

    // reset state
    @(negedge clk); @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_rdata", rd[d], 32'd0);
      check("reset_ready", 32'(rdy[d]), 32'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    foreach (tbl[i]) begin
      xfer(tbl[i].d, tbl[i].a, tbl[i].s, tbl[i].w, r, lat);
      check({tbl[i].name, "_lat"}, 32'(lat), 32'(tbl[i].lat));
      if (tbl[i].s == 4'h0) check({tbl[i].name, "_data"}, r, tbl[i].exp);
    end

    // back-to-back reads with two wait states
    address = 32'hA104; wstrobe = 4'h0; vld[1] = 1'b1;
    t1 = -1; t2 = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (rdy[1]) begin
        if (t1 < 0) begin
          t1 = i;
          check("b2b_first_data", rd[1], 32'h0BADF00D);
        end else begin
          t2 = i;
          check("b2b_second_data", rd[1], 32'h0BADF00D);
          break;
        end
      end
    end
    @(negedge clk);
    vld[1] = 1'b0;
    check("b2b_first_lat", 32'(t1), 32'd3);
    check("b2b_gap", 32'(t2 - t1), 32'd4);

    // window edges: last read on u_ws0 left rdata at 11111111
    hold_out(0, 32'hA400, 4'h0, 32'h0, hits);
    check("oow_above_ready", 32'(hits), 32'd0);
    check("oow_above_rdata", rd[0], 32'h11111111);
    hold_out(0, 32'h9FFC, 4'h0, 32'h0, hits);
    check("oow_below_ready", 32'(hits), 32'd0);
    check("oow_below_rdata", rd[0], 32'h11111111);
    hold_out(0, 32'hA400, 4'hF, 32'hFFFFFFFF, hits);
    check("oow_write_ready", 32'(hits), 32'd0);
    xfer(0, 32'hA000, 4'h0, 32'h0, r, lat);
    check("oow_no_alias", r, 32'h11111111);

    // write protection on u_ws2 (ROM_WORDS=4)
    xfer(1, 32'hA00C, 4'h0, 32'h0, old, lat);
    xfer(1, 32'hA00C, 4'hF, 32'hDEADBEEF, r, lat);
    check("rom_write_lat", 32'(lat), 32'd3);
    xfer(1, 32'hA00C, 4'h0, 32'h0, r, lat);
`ifdef VERMIBUS_RAM_ROM_PROTECT_EN
    check("rom_word3_kept", r, old);
    n_cmp++;
    if (r === 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL rom_word3_written: got %h want not deadbeef", r);
    end
`else
    check("rom_off_word3", r, 32'hDEADBEEF);
`endif
    xfer(1, 32'hA010, 4'hF, 32'hDEADBEEF, r, lat);
    xfer(1, 32'hA010, 4'h0, 32'h0, r, lat);
    check("rom_word4_written", r, 32'hDEADBEEF);

    // reset during WAIT of a write on u_ws3
    address = 32'hA010; wstrobe = 4'hF; wdata = 32'h12345678; vld[2] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; vld[2] = 1'b0;
    check("rst_mid_ready", 32'(rdy[2]), 32'd0);
    check("rst_mid_rdata", rd[2], 32'd0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy[2]) hits++;
    end
    check("rst_mid_no_ready", 32'(hits), 32'd0);
    xfer(2, 32'hA010, 4'h0, 32'h0, r, lat);
    check("rst_mid_old_value", r, 32'hAAAA5555);
    check("irq_low", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
